// File: rtl/blink_pkg.sv
// Purpose : shared types, tick constants and packed-parameter field extraction for the LED blink engine.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        FIN  = 2'd3
    } blink_state_t;

    // Phase lengths in cycles of the 12 MHz board clock.
    localparam logic [31:0] TICKS_0P5S = 32'd6000000;
    localparam logic [31:0] TICKS_1S   = 32'd12000000;
    localparam logic [31:0] TICKS_0P2S = 32'd2400000;

    // Packed pattern tables are zero-extended to PACK_MAX bits before field
    // extraction; a single field is at most FIELD_MAX bits wide.
    localparam int PACK_MAX  = 1024;
    localparam int FIELD_MAX = 32;

    // Returns entry idx (width w) of a packed table; entry 0 sits in the LSBs.
    function automatic logic [FIELD_MAX-1:0] pat_field(input logic [PACK_MAX-1:0] vec,
                                                       input int idx,
                                                       input int w);
        logic [PACK_MAX-1:0]  shifted;
        logic [FIELD_MAX-1:0] mask;
        shifted = vec >> (idx * w);
        // For w == FIELD_MAX the shift yields 0 and the subtraction wraps to all ones.
        mask    = (FIELD_MAX'(1) << w) - FIELD_MAX'(1);
        return FIELD_MAX'(shifted) & mask;
    endfunction

endpackage

// File: rtl/blink_phase_timer.sv
// Purpose : loadable down-counter timing one ON or OFF phase of the blink sequence.
// Latency : expire is high while the count is 0; load takes effect on the next edge.
// Backpressure: none; en simply holds the count when low, and the count never wraps below 0.
//
// Ports: hwclk clock, reset sync active-high, load/load_val preset, en count enable,
//        expire high when the count has reached 0.
module blink_phase_timer #(
    parameter int TICK_W = 32
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    input  logic              en,
    output logic              expire
);

    logic [TICK_W-1:0] cnt;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/blink_sequencer.sv
// Purpose : plays one of NUM_PATTERNS stored on/off blink patterns on a single LED per start request.
// Latency : start accepted in IDLE -> led high on the next cycle; busy = N*(on+off)+1 cycles.
// Backpressure: start is ignored while busy (no queueing); abort returns to IDLE on the next edge.
//
// Ports: hwclk clock, reset sync active-high, start request (IDLE only), pattern_sel index
//        (out-of-range selects pattern 0), abort, led (1 = lit), busy, done (1-cycle pulse).
// Optional: define BLINK_SEQ_LOOP_EN to add input 'loop'; loop=1 at FIN restarts the
//        pattern without a done pulse.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int                             NUM_PATTERNS = 4,
    parameter int                             TICK_W       = 32,
    parameter int                             CNT_W        = 4,
    parameter logic [NUM_PATTERNS*TICK_W-1:0] PAT_ON       = {4{TICKS_0P5S}},
    parameter logic [NUM_PATTERNS*TICK_W-1:0] PAT_OFF      = {4{TICKS_1S}},
    parameter logic [NUM_PATTERNS*CNT_W-1:0]  PAT_CNT      = {4{4'd3}},
    localparam int                            SEL_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] pattern_sel,
    input  logic             abort,
`ifdef BLINK_SEQ_LOOP_EN
    input  logic             loop,
`endif
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam logic [PACK_MAX-1:0] ON_X  = PACK_MAX'(PAT_ON);
    localparam logic [PACK_MAX-1:0] OFF_X = PACK_MAX'(PAT_OFF);
    localparam logic [PACK_MAX-1:0] CNT_X = PACK_MAX'(PAT_CNT);

    // A phase of length 0 is stretched to 1 cycle; the timer runs from len-1 down to 0.
    function automatic logic [TICK_W-1:0] phase_load(input logic [TICK_W-1:0] len);
        return (len == '0) ? '0 : (len - 1'b1);
    endfunction

    // Per-pattern timer preload values and blink counts.
    logic [TICK_W-1:0] on_ld_tab  [NUM_PATTERNS];
    logic [TICK_W-1:0] off_ld_tab [NUM_PATTERNS];
    logic [CNT_W-1:0]  cnt_tab    [NUM_PATTERNS];

    for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_tab
        localparam logic [TICK_W-1:0] ON_LEN  = TICK_W'(pat_field(ON_X,  i, TICK_W));
        localparam logic [TICK_W-1:0] OFF_LEN = TICK_W'(pat_field(OFF_X, i, TICK_W));
        assign on_ld_tab[i]  = phase_load(ON_LEN);
        assign off_ld_tab[i] = phase_load(OFF_LEN);
        assign cnt_tab[i]    = CNT_W'(pat_field(CNT_X, i, CNT_W));
    end

    logic [SEL_W-1:0] sel_idx;
    assign sel_idx = (32'(pattern_sel) < NUM_PATTERNS) ? pattern_sel : '0;

    blink_state_t      state, state_nxt;
    logic [TICK_W-1:0] on_ld, off_ld;
    logic [CNT_W-1:0]  cnt_lat, blink_cnt, blink_nxt;
    logic              accept, blink_clr, blink_inc;
    logic              tmr_load, tmr_en, tmr_expire;
    logic [TICK_W-1:0] tmr_load_val;

    assign blink_nxt = blink_cnt + 1'b1;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state     <= IDLE;
            on_ld     <= '0;
            off_ld    <= '0;
            cnt_lat   <= '0;
            blink_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                on_ld   <= on_ld_tab[sel_idx];
                off_ld  <= off_ld_tab[sel_idx];
                cnt_lat <= cnt_tab[sel_idx];
            end
            if (blink_clr) begin
                blink_cnt <= '0;
            end else if (blink_inc) begin
                blink_cnt <= blink_nxt;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        blink_clr    = 1'b0;
        blink_inc    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = on_ld;
        tmr_en       = 1'b0;
        case (state)
            IDLE: begin
                // start beats a simultaneous abort here; abort alone has no effect.
                if (start) begin
                    accept    = 1'b1;
                    blink_clr = 1'b1;
                    if (cnt_tab[sel_idx] == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt    = ON;
                        tmr_load     = 1'b1;
                        // Latches are not yet valid this cycle, so preload from the table.
                        tmr_load_val = on_ld_tab[sel_idx];
                    end
                end
            end
            ON: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tmr_expire) begin
                    state_nxt    = OFF;
                    tmr_load     = 1'b1;
                    tmr_load_val = off_ld;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            OFF: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tmr_expire) begin
                    blink_inc = 1'b1;
                    if (blink_nxt == cnt_lat) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt    = ON;
                        tmr_load     = 1'b1;
                        tmr_load_val = on_ld;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            FIN: begin
                if (abort) begin
                    state_nxt = IDLE;
`ifdef BLINK_SEQ_LOOP_EN
                end else if (loop) begin
                    state_nxt    = ON;
                    blink_clr    = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = on_ld;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    blink_phase_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .hwclk    (hwclk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    assign led  = (state == ON);
    assign busy = (state != IDLE);
    // An abort (or a loop restart) in FIN suppresses the completion pulse.
`ifdef BLINK_SEQ_LOOP_EN
    assign done = (state == FIN) && !abort && !loop;
`else
    assign done = (state == FIN) && !abort;
`endif

endmodule
